// File: rtl/sad_search_sequencer.sv
// sad_search_sequencer
//   Walks every WIN_W x WIN_H candidate window of a FRAME_W x FRAME_H frame in
//   raster order (x fastest), issuing one window per cycle to the SAD memory
//   stage. SAD results come back in issue order; the lowest SAD and its window
//   coordinates are tracked for the writeback min/minX/minY path.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        begin a search (sampled in IDLE only)
//   frame_base_i   byte address of pixel (0,0), captured on accepted start
//   stall_i        pipeline stall, blocks issue only
//   issue_valid_o  candidate window presented this cycle
//   issue_addr_o   frame_base + ((y*FRAME_W + x) << 2), modulo 2^32
//   issue_x_o/y_o  candidate window top-left
//   sad_valid_i    SAD result returning (oldest outstanding window)
//   sad_value_i    SAD of that window
//   busy_o         high from accepted start until done
//   done_o         one-cycle pulse at search completion
//   min_sad_o      best SAD so far (all ones after reset / start)
//   min_x_o/y_o    coordinates of best window
//   error_o        sticky: result arrived with nothing outstanding
//
// Optional build macro: SAD_EARLY_EXIT_EN
//   When defined, an accepted SAD of zero stops further issue; the search
//   drains the outstanding windows and then completes.

module sad_search_sequencer #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int WIN_W   = 4,
  parameter int WIN_H   = 4,
  parameter int MAX_OUT = 3,
  parameter int SAD_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      frame_base_i,
  input  logic             stall_i,
  output logic             issue_valid_o,
  output logic [31:0]      issue_addr_o,
  output logic [15:0]      issue_x_o,
  output logic [15:0]      issue_y_o,
  input  logic             sad_valid_i,
  input  logic [SAD_W-1:0] sad_value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SAD_W-1:0] min_sad_o,
  output logic [15:0]      min_x_o,
  output logic [15:0]      min_y_o,
  output logic             error_o
);

  localparam int X_MAX = FRAME_W - WIN_W;
  localparam int Y_MAX = FRAME_H - WIN_H;
  localparam int TOTAL = (X_MAX + 1) * (Y_MAX + 1);
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        frame_base_q;
  logic [15:0]        issue_x_q, issue_y_q;
  logic [15:0]        res_x_q, res_y_q;
  logic [CNT_W-1:0]   issued_q;
  logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [SAD_W-1:0]   min_sad_q;
  logic [15:0]        min_x_q, min_y_q;
  logic               error_q;

  logic               start_acc;
  logic               accept;
  logic               issue;
  logic               last_issue;
  logic               zero_hit;
  logic [31:0]        lin_off;

  assign start_acc  = (state_q == S_IDLE) && start_i;
  // A result with nothing outstanding is an error and is otherwise ignored.
  assign accept     = sad_valid_i && (out_cnt_q != '0);
  assign issue      = (state_q == S_SCAN) && !stall_i &&
                      (out_cnt_q < OUT_W'(MAX_OUT)) &&
                      (issued_q < CNT_W'(TOTAL));
  assign last_issue = issue && (issued_q == CNT_W'(TOTAL - 1));

`ifdef SAD_EARLY_EXIT_EN
  assign zero_hit = accept && (sad_value_i == '0);
`else
  assign zero_hit = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_SCAN;
      S_SCAN:  if (last_issue || zero_hit) state_d = S_DRAIN;
      // Nothing issues in DRAIN, so the last accepted result empties it.
      S_DRAIN: if ((out_cnt_q == '0) || (accept && (out_cnt_q == OUT_W'(1))))
                 state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    issue_valid_o = issue;
    busy_o        = (state_q == S_SCAN) || (state_q == S_DRAIN);
    done_o        = (state_q == S_DONE);
  end

  // Issue and result on the same cycle cancel out.
  always_comb begin
    out_cnt_d = out_cnt_q;
    if (issue && !accept)      out_cnt_d = out_cnt_q + OUT_W'(1);
    else if (!issue && accept) out_cnt_d = out_cnt_q - OUT_W'(1);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_base_q <= '0;
      issue_x_q    <= '0;
      issue_y_q    <= '0;
      res_x_q      <= '0;
      res_y_q      <= '0;
      issued_q     <= '0;
      out_cnt_q    <= '0;
      min_sad_q    <= '1;
      min_x_q      <= '0;
      min_y_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      if (sad_valid_i && (out_cnt_q == '0)) error_q <= 1'b1;

      if (start_acc) begin
        frame_base_q <= frame_base_i;
        issue_x_q    <= '0;
        issue_y_q    <= '0;
        res_x_q      <= '0;
        res_y_q      <= '0;
        issued_q     <= '0;
        out_cnt_q    <= '0;
        min_sad_q    <= '1;
        min_x_q      <= '0;
        min_y_q      <= '0;
      end else begin
        out_cnt_q <= out_cnt_d;

        if (issue) begin
          issued_q <= issued_q + CNT_W'(1);
          if (issue_x_q == 16'(X_MAX)) begin
            issue_x_q <= '0;
            issue_y_q <= issue_y_q + 16'd1;
          end else begin
            issue_x_q <= issue_x_q + 16'd1;
          end
        end

        if (accept) begin
          // Strict compare: ties keep the earliest raster position.
          if (sad_value_i < min_sad_q) begin
            min_sad_q <= sad_value_i;
            min_x_q   <= res_x_q;
            min_y_q   <= res_y_q;
          end
          if (res_x_q == 16'(X_MAX)) begin
            res_x_q <= '0;
            res_y_q <= res_y_q + 16'd1;
          end else begin
            res_x_q <= res_x_q + 16'd1;
          end
        end
      end
    end
  end

  assign lin_off      = 32'(issue_y_q) * 32'(FRAME_W) + 32'(issue_x_q);
  assign issue_addr_o = frame_base_q + (lin_off << 2);
  assign issue_x_o    = issue_x_q;
  assign issue_y_o    = issue_y_q;
  assign min_sad_o    = min_sad_q;
  assign min_x_o      = min_x_q;
  assign min_y_o      = min_y_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_sad_search_sequencer.sv
// Testbench for sad_search_sequencer on an 8x8 frame with 4x4 windows
// (5x5 = 25 positions). Expected issue positions are queued at start and
// popped as the DUT issues; a responder returns SAD values from a table
// after a programmable latency.

module tb_sad_search_sequencer;

  localparam int FW  = 8;
  localparam int FH  = 8;
  localparam int WW  = 4;
  localparam int WH  = 4;
  localparam int MO  = 3;
  localparam int SW  = 32;
  localparam int NX  = FW - WW + 1;
  localparam int NY  = FH - WH + 1;
  localparam int TOT = NX * NY;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   frame_base;
  logic          stall;
  logic          issue_valid;
  logic [31:0]   issue_addr;
  logic [15:0]   issue_x, issue_y;
  logic          sad_valid;
  logic [SW-1:0] sad_value;
  logic          busy, done;
  logic [SW-1:0] min_sad;
  logic [15:0]   min_x, min_y;
  logic          error;

  always #5 clk = ~clk;

  sad_search_sequencer #(
    .FRAME_W(FW), .FRAME_H(FH), .WIN_W(WW), .WIN_H(WH), .MAX_OUT(MO), .SAD_W(SW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .frame_base_i(frame_base),
    .stall_i(stall), .issue_valid_o(issue_valid), .issue_addr_o(issue_addr),
    .issue_x_o(issue_x), .issue_y_o(issue_y), .sad_valid_i(sad_valid),
    .sad_value_i(sad_value), .busy_o(busy), .done_o(done), .min_sad_o(min_sad),
    .min_x_o(min_x), .min_y_o(min_y), .error_o(error)
  );

  typedef struct { logic [15:0] x; logic [15:0] y; logic [31:0] addr; } iss_t;
  typedef struct { int due; logic [31:0] val; } rsp_t;

  iss_t exp_q[$];
  rsp_t rsp_q[$];
  int   sad_tab[TOT];
  int   cyc = 0;
  int   lat = 2;
  int   errors = 0;
  int   checks = 0;
  int   n_iss, n_done;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic fill_tab(input int v);
    for (int i = 0; i < TOT; i++) sad_tab[i] = v;
  endtask

  // One search. stall_at: 5-cycle stall after that many issues (-1 none).
  // hold: withhold results from the start. reset_at: async reset after that
  // many issues (-1 none); the task returns once reset is released.
  task automatic run_scan(input logic [31:0] base, input int stall_at, input bit hold,
                          input int reset_at, output int o_iss, output int o_done);
    int   stall_left, stall_pend, stall_acc, hold_cyc, release_n, done_cyc;
    bit   holding;
    iss_t e;
    int   idx;
    stall_left = 0; stall_pend = 0; stall_acc = 0; hold_cyc = 0;
    release_n = 0; done_cyc = 0; holding = hold;
    o_iss = 0; o_done = 0;
    exp_q.delete();
    rsp_q.delete();
    for (int y = 0; y < NY; y++)
      for (int x = 0; x < NX; x++)
        exp_q.push_back('{x: 16'(x), y: 16'(y), addr: base + 32'((y * FW + x) * 4)});

    @(negedge clk);
    frame_base = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);

    for (int c = 0; c < 400; c++) begin
      stall = (stall_left > 0);
      sad_valid = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc && (!holding || release_n > 0)) begin
        sad_valid = 1'b1;
        sad_value = rsp_q[0].val;
        void'(rsp_q.pop_front());
        if (holding) release_n--;
        if (stall) stall_acc++;
        $display("result cyc=%0d sad=%0d", cyc, sad_value);
      end
      #1;
      if (stall) check_eq("no_issue_in_stall", issue_valid, 0);
      if (issue_valid) begin
        check_eq("issue_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("issue cyc=%0d x=%0d y=%0d addr=0x%08h", cyc, issue_x, issue_y, issue_addr);
          check_eq("issue_x", issue_x, e.x);
          check_eq("issue_y", issue_y, e.y);
          check_eq("issue_addr", issue_addr, e.addr);
          idx = int'(e.y) * NX + int'(e.x);
          rsp_q.push_back('{due: cyc + lat, val: 32'(sad_tab[idx])});
          o_iss++;
          if (o_iss == stall_at) begin
            stall_left = 5;
            stall_pend = rsp_q.size();
            stall_acc  = 0;
          end
          if (o_iss == reset_at) begin
            rst = 1'b1;
            #1;
            check_eq("rst_busy", busy, 0);
            check_eq("rst_issue_valid", issue_valid, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_issue_addr", issue_addr, 0);
            check_eq("rst_min_sad", min_sad, {SW{1'b1}});
            check_eq("rst_min_x", min_x, 0);
            check_eq("rst_min_y", min_y, 0);
            @(negedge clk);
            rst = 1'b0;
            break;
          end
        end
      end
      if (done) begin
        o_done++;
        done_cyc = cyc;
        $display("done cyc=%0d min=%0d at (%0d,%0d)", cyc, min_sad, min_x, min_y);
      end
      if (stall) begin
        stall_left--;
        if (stall_left == 0) check_eq("stall_results_drained", stall_acc, stall_pend);
      end
      if (holding) begin
        hold_cyc++;
        if (hold_cyc == 8) begin
          check_eq("max_out_issues", o_iss, MO);
          release_n = 1;
        end
        if (hold_cyc == 16) begin
          check_eq("one_more_issue", o_iss, MO + 1);
          holding = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
      if (o_done > 0 && cyc >= done_cyc + 3) break;
    end
    sad_valid = 1'b0;
    stall = 1'b0;
  endtask

  task automatic check_full(input string tag, input logic [31:0] ms, input int mx, input int my);
    check_eq({tag, "_issues"}, n_iss, TOT);
    check_eq({tag, "_done_once"}, n_done, 1);
    check_eq({tag, "_all_positions"}, exp_q.size(), 0);
    check_eq({tag, "_min_sad"}, min_sad, ms);
    check_eq({tag, "_min_x"}, min_x, mx);
    check_eq({tag, "_min_y"}, min_y, my);
    check_eq({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; sad_valid = 1'b0;
    sad_value = '0; frame_base = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_issue_valid", issue_valid, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_min_sad", min_sad, {SW{1'b1}});
    check_eq("reset_min_x", min_x, 0);
    check_eq("reset_min_y", min_y, 0);
    check_eq("reset_error", error, 0);
    rst = 1'b0;

    // Constant SAD: first window wins.
    lat = 2; fill_tab(50);
    run_scan(32'h1000, -1, 1'b0, -1, n_iss, n_done);
    check_full("const", 50, 0, 0);
    check_eq("const_error", error, 0);

    // Two equal minima: earlier raster position (3,2) kept over (1,4).
    fill_tab(20);
    sad_tab[2 * NX + 3] = 9;
    sad_tab[4 * NX + 1] = 9;
    run_scan(32'h1000, -1, 1'b0, -1, n_iss, n_done);
    check_full("tie", 9, 3, 2);

    // Stall mid-scan with longer latency so the window fills.
    lat = 3; fill_tab(50);
    sad_tab[3 * NX + 4] = 7;
    run_scan(32'h1000, 8, 1'b0, -1, n_iss, n_done);
    check_full("stall", 7, 4, 3);

    // Results withheld: issue stops at MAX_OUT; each release lets one more go.
    lat = 2; fill_tab(30);
    sad_tab[0] = 31;
    sad_tab[1] = 12;
    run_scan(32'hFFFF_FFF0, -1, 1'b1, -1, n_iss, n_done);
    check_full("hold", 12, 1, 0);
    check_eq("hold_error", error, 0);

`ifdef SAD_EARLY_EXIT_EN
    // Zero SAD at position 6 = (1,1): issue stops, drain, then done.
    fill_tab(20);
    sad_tab[1 * NX + 1] = 0;
    run_scan(32'h1000, -1, 1'b0, -1, n_iss, n_done);
    check_eq("early_done_once", n_done, 1);
    check_eq("early_issue_bound", n_iss <= 6 + MO, 1);
    check_eq("early_min_sad", min_sad, 0);
    check_eq("early_min_x", min_x, 1);
    check_eq("early_min_y", min_y, 1);
`endif

    // Reset at issue 10, then a stray result, then a clean full search.
    fill_tab(50);
    run_scan(32'h1000, -1, 1'b0, 10, n_iss, n_done);
    check_eq("reset_mid_error_clear", error, 0);
    sad_valid = 1'b1;
    sad_value = 32'd5;
    @(negedge clk);
    sad_valid = 1'b0;
    check_eq("late_result_error", error, 1);
    check_eq("late_result_min_kept", min_sad, {SW{1'b1}});
    fill_tab(40);
    sad_tab[24] = 3;
    run_scan(32'h1000, -1, 1'b0, -1, n_iss, n_done);
    check_full("after_reset", 3, 4, 4);
    check_eq("error_sticky", error, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
